// File: rtl/power2round_stream.sv
// Streaming Dilithium Power2Round: splits each t coefficient into t1 and packed t0,
// counting beats against k_num*256 and pulsing done after the final output.
module power2round_stream #(
  parameter int K_MAX = 8,
  parameter int Q     = 8380417,
  parameter int D     = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  k_num,
  input  logic        t_valid,
  input  logic [22:0] t_data,
  output logic        t1_valid,
  output logic [9:0]  t1_data,
  output logic [12:0] t0_pack,
  output logic [2:0]  out_poly,
  output logic [7:0]  out_coef,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [23:0] RND  = 24'((1 << (D - 1)) - 1);
  localparam logic [23:0] HALF = 24'(1 << (D - 1));

  state_e      state_q, state_d;
  logic [11:0] target_q, target_d;
  logic [11:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        accept, flush, k_ok;

  logic        s1_v_q;
  logic [22:0] s1_t_q;
  logic [23:0] s1_sum_q;
  logic [10:0] s1_idx_q;

  logic        s2_v_q;
  logic [9:0]  s2_t1_q;
  logic [12:0] s2_t0_q;
  logic [10:0] s2_idx_q;

  assign k_ok = (k_num != 4'd0) && (32'(k_num) <= K_MAX);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    accept   = 1'b0;
    flush    = 1'b0;
    if (start) begin
      // Any start restarts from scratch; a beat in this cycle is dropped.
      flush = 1'b1;
      cnt_d = '0;
      if (k_ok) begin
        state_d  = S_RUN;
        target_d = {k_num, 8'd0};
        err_d    = 1'b0;
      end else begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (t_valid) err_d = 1'b1;
        end
        S_RUN: begin
          if (t_valid) begin
            accept = 1'b1;
            cnt_d  = cnt_q + 12'd1;
            if (32'(t_data) >= Q) err_d = 1'b1;
            if (cnt_q == target_q - 12'd1) state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (t_valid) err_d = 1'b1;
          if (!s1_v_q) state_d = S_DONE;
        end
        S_DONE: begin
          if (t_valid) err_d = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      target_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_t_q   <= '0;
      s1_sum_q <= '0;
      s1_idx_q <= '0;
    end else begin
      s1_v_q <= accept;
      if (accept) begin
        s1_t_q   <= t_data;
        s1_sum_q <= {1'b0, t_data} + RND;
        s1_idx_q <= cnt_q[10:0];
      end
    end
  end

  // t0_pack = 2^(D-1) - (t - t1*2^D), reduced to D bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v_q   <= 1'b0;
      s2_t1_q  <= '0;
      s2_t0_q  <= '0;
      s2_idx_q <= '0;
    end else begin
      s2_v_q <= s1_v_q & ~flush;
      if (s1_v_q && !flush) begin
        s2_t1_q  <= 10'(s1_sum_q >> D);
        s2_t0_q  <= 13'(HALF - ({1'b0, s1_t_q} - ((s1_sum_q >> D) << D)));
        s2_idx_q <= s1_idx_q;
      end
    end
  end

  assign t1_valid = s2_v_q;
  assign t1_data  = s2_t1_q;
  assign t0_pack  = s2_t0_q;
  assign out_poly = s2_idx_q[10:8];
  assign out_coef = s2_idx_q[7:0];
  assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);
  assign err      = err_q;

endmodule

// File: doc/power2round_stream.md
# power2round_stream

Streaming Power2Round stage for Dilithium KeyGen. It takes the t = A·s1 + s2 coefficient stream, one 23-bit coefficient in [0, q) per beat. For each coefficient it emits t1 (10 bits, consumed directly by the public-key packer's `t1_valid`/`t1_data`) and packed t0 (13 bits, for the secret-key packer). It counts coefficients against the selected parameter set and signals completion.

## Interface
- `K_MAX`, default 8: maximum polynomial count in vector t (Dilithium5).
- `Q`, default 8380417: modulus.
- `D`, default 13: dropped bits.

Ports:
- `clk`, in, 1: clock; all logic on rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: one-cycle pulse; samples `k_num` and arms the block.
- `k_num`, in, 4: polynomials to process; legal 1..K_MAX (4/6/8 in use).
- `t_valid`, in, 1: input beat valid; there is no ready, so the source must not exceed the count.
- `t_data`, in, 23: coefficient t, unsigned.
- `t1_valid`, out, 1: output beat valid (also qualifies `t0_pack`, `out_poly`, `out_coef`).
- `t1_data`, out, 10: t1.
- `t0_pack`, out, 13: 2^(D-1) − t0, in [0, 8191].
- `out_poly`, out, 3: polynomial index of the output beat.
- `out_coef`, out, 8: coefficient index of the output beat.
- `busy`, out, 1: high in RUN and DRAIN.
- `done`, out, 1: one-cycle pulse after the final output beat.
- `err`, out, 1: sticky error flag; cleared only by `start` (legal `k_num`) or `rst`.

## Operation
- Arithmetic:
  - t1 = (t + 2^(D-1) − 1) >> D, which fits in 10 bits for t < q.
  - t0 = t − t1·2^D, in (−4096, 4096].
  - t0_pack = 4096 − t0, taken modulo 2^13.
  - The intermediate sum uses 24 bits and is never truncated before the shift.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start` with 1 ≤ `k_num` ≤ K_MAX. Load `target = k_num·256` and clear the input counter.
  - IDLE stays IDLE on `start` with illegal `k_num`; `err` is set.
  - RUN: each `t_valid` beat is accepted and the input counter increments. After accepting beat number target−1, go to DRAIN.
  - DRAIN: wait until the last beat leaves the pipeline, then go to DONE.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- Pipeline: two register stages.
  - Stage 1 registers t, the sum, and the indices.
  - Stage 2 registers t1, t0_pack, and the indices.
- Output index counters advance with output beats: `out_coef` wraps 255→0 and increments `out_poly`.
- Error sources (each sets `err`; the beat is still processed where noted):
  - `t_data` ≥ Q in RUN: beat processed anyway, output values follow the formula.
  - `t_valid` in IDLE, DRAIN or DONE: beat dropped, not counted.
  - Illegal `k_num` at `start`.
- `start` while busy: abort.
  - In-flight pipeline beats are discarded (valid bits cleared) and counters are cleared.
  - `k_num` is re-sampled; `done` does not fire for the aborted run.
  - `err` is cleared if the new `k_num` is legal.
- A `t_valid` beat in the same cycle as `start` is dropped and does not set `err`.

## Timing
- Reset values:
  - `t1_valid`, `busy`, `done`, `err` = 0.
  - `t1_data`, `t0_pack`, `out_poly`, `out_coef` = 0.
  - FSM in IDLE; all counters and pipeline valid bits = 0.
  - Reset mid-run discards everything, with no `done` pulse.
- Latency: a beat accepted at cycle N appears at the outputs in cycle N+2, for one cycle.
- Throughput: one beat per cycle; gaps in `t_valid` propagate as gaps in `t1_valid`.
- `done`: pulses in cycle L+1, where L is the cycle of the final output beat.
- `busy`:
  - Rises the cycle after `start`.
  - Falls in the same cycle `done` is asserted.
- Minimum run: k_num=1 with 256 back-to-back beats from cycle S+1 gives outputs at S+3..S+258 and `done` at S+259.

## Test plan
- Boundary coefficients: t = 0, 4096, 4097, 8380416.
  - Required (t1, t0_pack) = (0,4096), (0,0), (1,8191), (1023,4096).
  - Each output appears 2 cycles after its input beat.
- Full Dilithium2 run: `k_num`=4 with 1024 random legal beats, including random `t_valid` gaps.
  - Outputs must match the reference model bit-exactly, with `out_poly`/`out_coef` running 0/0..3/255.
  - Exactly 1024 `t1_valid` beats, one `done` pulse, `err`=0.
- Overrun and out-of-range input:
  - Beat 1025 in a `k_num`=4 run is dropped and sets `err`.
  - `t_data`=8380417 in a separate run sets `err`; that beat's output is t1=1023, t0_pack=4095.
- Abort: `start` with `k_num`=6 at beat 300 of a `k_num`=4 run.
  - No stale outputs after the abort.
  - The next 1536 beats complete normally, with one `done` pulse.
- Illegal `k_num` values 0 and 9: FSM stays IDLE, `busy`=0, `err`=1.
- Asynchronous `rst` pulse mid-run (not aligned to `clk`): all outputs read 0 immediately, and a following legal run completes correctly.
